// File: rtl/wb_loader.sv
// Purpose: byte-stream command loader driving a 24-bit address / 8-bit data Wishbone initiator.
// Latency: bus cycle starts the clock after its data/count byte; cyc/stb drop the clock after ack or timeout.
// Backpressure: rx_ready low while a bus cycle or read-back byte is outstanding; tx_data/tx_valid held until tx_ready.
//
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   rx_data/valid/ready    host command stream (SETADDR 0x01, WRITE 0x02, READ 0x03)
//   tx_data/valid/ready    read-back byte stream to the host
//   wb_*                   Wishbone initiator (24-bit address, 8-bit data, one select bit)
//   busy                   high whenever the FSM is not idle
//   timeout_err            sticky bus-timeout flag, cleared by the next SETADDR command
module wb_loader #(
    parameter int timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [23:0] wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic [0:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        IDLE, ADDR0, ADDR1, ADDR2, COUNT, WDATA, WBUS, RBUS, RSEND
    } state_t;

    // Last wait-counter value before the abort edge: a cycle that has waited
    // timeout_cycles clocks without ack is terminated.
    localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

    state_t      state_q;
    logic [23:0] adr_q;
    logic [7:0]  dat_q;
    logic [8:0]  cnt_q;
    logic [15:0] tmo_q;
    logic        is_wr_q;
    logic        cyc_q;
    logic        we_q;
    logic [7:0]  tx_dat_q;
    logic        tx_vld_q;
    logic        terr_q;

    logic        rx_fire;
    logic        bus_end;
    logic [23:0] adr_d;
    logic [8:0]  cnt_d;
    logic        last_xfer;

    // rx_ready is decoded from the state so it is already high in the first
    // clock after reset release, and forced low while reset is held.
    assign rx_ready  = reset_n && (state_q == IDLE  || state_q == ADDR0 || state_q == ADDR1 ||
                                   state_q == ADDR2 || state_q == COUNT || state_q == WDATA);
    assign rx_fire   = rx_valid && rx_ready;

    // Ack wins over the terminal count when both land on the same edge.
    assign bus_end   = wb_ack_i || (tmo_q == TMO_LAST);
    assign adr_d     = adr_q + 24'd1;
    assign cnt_d     = cnt_q - 9'd1;
    assign last_xfer = (cnt_q == 9'd1);

    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_cyc_o    = cyc_q;
    assign tx_data     = tx_dat_q;
    assign tx_valid    = tx_vld_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            is_wr_q  <= 1'b0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            tx_dat_q <= '0;
            tx_vld_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_fire) begin
                        case (rx_data)
                            8'h01: begin
                                state_q <= ADDR0;
                                terr_q  <= 1'b0;
                            end
                            8'h02: begin
                                is_wr_q <= 1'b1;
                                state_q <= COUNT;
                            end
                            8'h03: begin
                                is_wr_q <= 1'b0;
                                state_q <= COUNT;
                            end
                            default: ; // unknown command byte is discarded
                        endcase
                    end
                end
                // Address arrives most significant byte first.
                ADDR0: if (rx_fire) begin
                    adr_q[23:16] <= rx_data;
                    state_q      <= ADDR1;
                end
                ADDR1: if (rx_fire) begin
                    adr_q[15:8] <= rx_data;
                    state_q     <= ADDR2;
                end
                ADDR2: if (rx_fire) begin
                    adr_q[7:0] <= rx_data;
                    state_q    <= IDLE;
                end
                COUNT: if (rx_fire) begin
                    // A zero count byte encodes 256 transfers.
                    cnt_q <= {(rx_data == 8'h00), rx_data};
                    if (is_wr_q) begin
                        state_q <= WDATA;
                    end else begin
                        state_q <= RBUS;
                        cyc_q   <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                WDATA: if (rx_fire) begin
                    dat_q   <= rx_data;
                    state_q <= WBUS;
                    cyc_q   <= 1'b1;
                    we_q    <= 1'b1;
                    tmo_q   <= '0;
                end
                WBUS: begin
                    if (bus_end) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (!wb_ack_i) terr_q <= 1'b1;
                        adr_q   <= adr_d;
                        cnt_q   <= cnt_d;
                        state_q <= last_xfer ? IDLE : WDATA;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                RBUS: begin
                    if (bus_end) begin
                        cyc_q    <= 1'b0;
                        tx_vld_q <= 1'b1;
                        tx_dat_q <= wb_ack_i ? wb_dat_i : 8'hFF;
                        if (!wb_ack_i) terr_q <= 1'b1;
                        state_q  <= RSEND;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                RSEND: begin
                    if (tx_ready) begin
                        tx_vld_q <= 1'b0;
                        adr_q    <= adr_d;
                        cnt_q    <= cnt_d;
                        if (last_xfer) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= RBUS;
                            cyc_q   <= 1'b1;
                            tmo_q   <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_loader.sv
module tb_wb_loader;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [23:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i = 8'h00;
    logic        wb_we_o;
    logic [0:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    wb_loader #(.timeout_cycles(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        bit        we;
        bit [23:0] adr;
        bit [7:0]  dat;
        int        len;
    } bus_exp_t;

    bus_exp_t  exp_bus[$];
    bit [7:0]  exp_tx[$];
    int        plan_ack[$];
    bit [7:0]  plan_dat[$];
    bit [7:0]  byte_q[$];
    int        ack_fix = -1;
    int        n_chk = 0;
    int        n_fail = 0;
    bit [23:0] m_adr = '0;
    bit        m_terr = 1'b0;
    int        stall_left = 0;
    bit        mon_en = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- target model and monitor (negedge) ----------------
    int        cnt = 0;
    int        cur_ack = 0;
    bit [7:0]  cur_dat;
    bit [23:0] cyc_adr;
    bit        cyc_we;
    bit [7:0]  cyc_wdat;
    bit        cyc_stable;
    bit        prev_pend = 1'b0;
    bit [7:0]  prev_tx;

    always @(negedge clk) begin
        if (!reset_n) begin
            cnt       = 0;
            wb_ack_i  = 1'b0;
            tx_ready  = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (wb_cyc_o) begin
                if (cnt == 0) begin
                    cyc_adr    = wb_adr_o;
                    cyc_we     = wb_we_o;
                    cyc_wdat   = wb_dat_o;
                    cyc_stable = 1'b1;
                    if (plan_ack.size() > 0) begin
                        cur_ack = plan_ack.pop_front();
                        cur_dat = plan_dat.pop_front();
                    end else begin
                        cur_ack = 0;
                        cur_dat = 8'h00;
                    end
                end
                if (wb_adr_o !== cyc_adr || wb_we_o !== cyc_we || wb_stb_o !== 1'b1 ||
                    wb_sel_o !== 1'b1 || (cyc_we && wb_dat_o !== cyc_wdat))
                    cyc_stable = 1'b0;
                cnt++;
                wb_ack_i = (cnt == cur_ack);
                wb_dat_i = wb_ack_i ? cur_dat : 8'($urandom);
            end else begin
                if (cnt > 0 && mon_en) begin
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected_cycle", 32'(cyc_adr), 32'hFFFF_FFFF);
                    end else begin
                        bus_exp_t e;
                        e = exp_bus.pop_front();
                        chk("bus_we", 32'(cyc_we), 32'(e.we));
                        chk("bus_adr", 32'(cyc_adr), 32'(e.adr));
                        if (e.we) chk("bus_wdat", 32'(cyc_wdat), 32'(e.dat));
                        chk("bus_cyc_len", 32'(cnt), 32'(e.len));
                        chk("bus_stable", 32'(cyc_stable), 32'd1);
                    end
                end
                cnt = 0;
                // Stray acks while no cycle is open must be ignored.
                wb_ack_i = ($urandom_range(0, 7) == 0);
                wb_dat_i = 8'($urandom);
            end

            if (prev_pend) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(prev_tx));
            end
            if (stall_left > 0 && tx_valid) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = ($urandom_range(0, 2) != 0);
            end
            if (tx_valid && tx_ready && mon_en) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            prev_pend = tx_valid && !tx_ready;
            prev_tx   = tx_data;
        end
    end

    // ---------------- stimulus and reference model ----------------
    task automatic send_byte(input bit [7:0] b);
        int budget = 2000;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("rx_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic int pick_ack();
        int r;
        if (ack_fix >= 0) return ack_fix;
        r = int'($urandom_range(0, 7));
        if (r < 6) return 1 + (r % 4);
        return (r == 6) ? 0 : 6;
    endfunction

    function automatic bit [7:0] next_byte();
        if (byte_q.size() > 0) return byte_q.pop_front();
        return 8'($urandom);
    endfunction

    task automatic cmd_setaddr(input bit [23:0] a);
        send_byte(8'h01);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        m_adr  = a;
        m_terr = 1'b0;
    endtask

    task automatic cmd_write(input bit [7:0] nb);
        int n = (nb == 8'h00) ? 256 : int'(nb);
        send_byte(8'h02);
        send_byte(nb);
        for (int i = 0; i < n; i++) begin
            bus_exp_t e;
            bit [7:0] d;
            int a;
            bit tout;
            d = next_byte();
            a = pick_ack();
            tout = !(a >= 1 && a <= TMO);
            plan_ack.push_back(a);
            plan_dat.push_back(8'h00);
            e.we = 1'b1; e.adr = m_adr; e.dat = d; e.len = tout ? TMO : a;
            exp_bus.push_back(e);
            m_terr = m_terr | tout;
            m_adr  = m_adr + 24'd1;
            send_byte(d);
        end
    endtask

    task automatic cmd_read(input bit [7:0] nb);
        int n = (nb == 8'h00) ? 256 : int'(nb);
        for (int i = 0; i < n; i++) begin
            bus_exp_t e;
            bit [7:0] d;
            int a;
            bit tout;
            d = next_byte();
            a = pick_ack();
            tout = !(a >= 1 && a <= TMO);
            plan_ack.push_back(a);
            plan_dat.push_back(d);
            e.we = 1'b0; e.adr = m_adr; e.dat = 8'h00; e.len = tout ? TMO : a;
            exp_bus.push_back(e);
            exp_tx.push_back(tout ? 8'hFF : d);
            m_terr = m_terr | tout;
            m_adr  = m_adr + 24'd1;
        end
        send_byte(8'h03);
        send_byte(nb);
    endtask

    task automatic wait_idle(input string tag);
        int budget = 20000;
        while ((busy || tx_valid || exp_bus.size() > 0 || exp_tx.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({tag, "_idle_reached"}, 32'(budget > 0), 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(m_terr));
        chk({tag, "_adr"}, 32'(wb_adr_o), 32'(m_adr));
        if (budget == 0) begin
            exp_bus.delete(); exp_tx.delete(); plan_ack.delete(); plan_dat.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while reset is held.
        #12;
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", 32'(wb_dat_o), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rst_release_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);

        // Two-byte write, ack after one cycle.
        ack_fix = 1;
        cmd_setaddr(24'h123456);
        byte_q = '{8'hAA, 8'hBB};
        cmd_write(8'h02);
        wait_idle("write2");

        // Read across the address wrap with a 10-cycle tx stall.
        ack_fix = 2;
        cmd_setaddr(24'hFFFFFF);
        byte_q = '{8'h5A, 8'hC3};
        stall_left = 10;
        cmd_read(8'h02);
        wait_idle("read_wrap");

        // Read with no ack: timeout, 0xFF returned, sticky error.
        ack_fix = 0;
        cmd_read(8'h01);
        wait_idle("read_timeout");
        ack_fix = 1;
        cmd_setaddr(24'h000100);
        wait_idle("setaddr_clears");

        // Ack on the terminal-count edge is a real ack.
        ack_fix = TMO;
        byte_q = '{8'h3C};
        cmd_read(8'h01);
        byte_q = '{8'h77};
        cmd_write(8'h01);
        wait_idle("ack_at_terminal");

        // Count byte 0 means 256 writes; address wraps past 0xFFFFFF.
        ack_fix = -1;
        cmd_setaddr(24'hFFFF80);
        cmd_write(8'h00);
        wait_idle("write256");

        // Unknown command byte is dropped with no bus activity.
        send_byte(8'h7F);
        for (int i = 0; i < 3; i++) begin
            chk("junk_no_cyc", 32'(wb_cyc_o), 32'd0);
            @(negedge clk);
        end
        cmd_setaddr(24'hABCDEF);
        wait_idle("junk_then_setaddr");

        // Randomized command mix.
        for (int it = 0; it < 40; it++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 2) begin
                cmd_setaddr(24'($urandom));
            end else if (r < 5) begin
                cmd_write(8'($urandom_range(1, 6)));
            end else if (r < 8) begin
                cmd_read(8'($urandom_range(1, 6)));
            end else begin
                send_byte(8'($urandom_range(4, 255)));
            end
            if (it % 8 == 7) wait_idle("random");
        end
        wait_idle("random_end");

        // Reset in the middle of a write bus cycle.
        ack_fix = -1;
        cmd_setaddr(24'h5A5A5A);
        wait_idle("pre_reset");
        mon_en = 1'b0;
        send_byte(8'h02);
        send_byte(8'h01);
        plan_ack.push_back(0);
        plan_dat.push_back(8'h00);
        send_byte(8'hE1);
        chk("midrst_cyc_open", 32'(wb_cyc_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("midrst_stb", 32'(wb_stb_o), 32'd0);
        chk("midrst_we", 32'(wb_we_o), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_adr", 32'(wb_adr_o), 32'd0);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        exp_bus.delete(); exp_tx.delete(); plan_ack.delete(); plan_dat.delete();
        m_adr = '0;
        m_terr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("midrst_release_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        mon_en = 1'b1;
        ack_fix = 2;
        cmd_write(8'h02);
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
